lab2_proc_int_muldiv_iter: RTL and testbench

- Parametrised iterative integer multiply/divide unit. It is the next-generation replacement for the fixed 32-bit, multiply-only unit in the processor X stage.
- Supports all eight RV32M operations at configurable width, behind the same val/rdy stream interface.
- Issued from D, with the response consumed in X.
- Variable latency:
  - W-cycle iteration for normal operations.
  - Single-cycle fast path for divide special cases.

---
 rtl/lab2_proc_int_muldiv_iter.sv | 375 +++++++++++++++++++++++++++++++++++++
 tb/tb_lab2_proc_int_muldiv_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_int_muldiv_iter.sv
// ============================================================================
// lab2_proc_int_muldiv_iter
// ----------------------------------------------------------------------------
// Iterative integer multiply/divide unit implementing all eight RV32M
// operations at a configurable width W, behind a val/rdy stream interface.
// Requests are issued from D and the response is consumed in X.
//
//   fn encoding (RV32M funct3):
//     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//
//   Normal operations take W iteration cycles: accept at edge 0, CALC in
//   cycles 1..W, response valid from cycle W+1. Divide special cases
//   (divide-by-zero, signed overflow) are resolved at accept and the
//   response is valid in cycle 1.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   istream_val  in   request valid
//   istream_rdy  out  request ready (high only in IDLE)
//   istream_msg  in   {fn[2:0], a[W-1:0], b[W-1:0]}
//   ostream_val  out  response valid (high only in DONE)
//   ostream_rdy  in   response ready
//   ostream_msg  out  W-bit result, registered
//   busy         out  high whenever the unit is not IDLE
//
// Build option:
//   LAB2_PROC_MULDIV_EARLY_OUT_EN - when defined, MUL leaves CALC as soon as
//   the remaining multiplier magnitude is zero, and MUL with b==0 completes
//   directly from IDLE. When undefined, no early-out logic exists.
// ============================================================================
module lab2_proc_int_muldiv_iter #(
    parameter int p_width    = 32,
    parameter int p_cnt_bits = $clog2(p_width) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [2*p_width+2:0]   istream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [p_width-1:0]     ostream_msg,
    output logic                   busy
);

    localparam int W = p_width;

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    localparam logic [p_cnt_bits-1:0] CNT_ONE  = p_cnt_bits'(1);
    localparam logic [p_cnt_bits-1:0] CNT_INIT = p_cnt_bits'(p_width);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate of a W-bit value when en is set.
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic en);
        logic [W-1:0] r;
        if (en) begin
            r = {W{1'b0}} - x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Two's-complement negate of a 2W-bit value when en is set.
    function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] x, input logic en);
        logic [2*W-1:0] r;
        if (en) begin
            r = {(2*W){1'b0}} - x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 state_r;
    logic [p_cnt_bits-1:0]  cnt_r;
    logic [2:0]             fn_r;
    logic                   sign_fix_r;   // negate result at the end
    logic [2*W-1:0]         acc_r;        // multiply accumulator
    logic [2*W-1:0]         mcand_r;      // multiplicand, shifted left
    logic [W-1:0]           mplier_r;     // multiplier, shifted right
    logic [W-1:0]           rem_r;        // divide partial remainder
    logic [W-1:0]           quo_r;        // dividend in, quotient out
    logic [W-1:0]           divisor_r;
    logic [W-1:0]           result_r;
    logic                   istream_rdy_r;
    logic                   ostream_val_r;
    logic                   busy_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                 state_next_s;
    logic [2:0]             fn_s;
    logic [W-1:0]           a_s;
    logic [W-1:0]           b_s;
    logic                   a_signed_s;
    logic                   b_signed_s;
    logic [W-1:0]           a_mag_s;
    logic [W-1:0]           b_mag_s;
    logic                   neg_q_s;
    logic                   neg_r_s;
    logic                   b_zero_s;
    logic                   ovf_s;
    logic                   special_s;
    logic [W-1:0]           special_res_s;
    logic                   accept_s;

    logic [2*W-1:0]         acc_step_s;
    logic [2*W-1:0]         mcand_step_s;
    logic [W-1:0]           mplier_step_s;
    logic [W:0]             rem_shift_s;
    logic [W:0]             diff_s;
    logic [W-1:0]           rem_step_s;
    logic [W-1:0]           quo_step_s;
    logic [2*W-1:0]         prod_s;
    logic [W-1:0]           final_res_s;
    logic                   last_iter_s;

    assign fn_s = istream_msg[2*W+2 -: 3];
    assign a_s  = istream_msg[2*W-1 -: W];
    assign b_s  = istream_msg[W-1:0];

    assign accept_s = (state_r == ST_IDLE) && istream_val;

    // Request decode: operand signedness, magnitudes and special cases.
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        special_s     = 1'b0;
        special_res_s = {W{1'b0}};

        case (fn_s)
            FN_MULH:        begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            FN_MULHSU:      begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            FN_DIV, FN_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase

        a_mag_s  = cond_neg_w(a_s, a_signed_s & a_s[W-1]);
        b_mag_s  = cond_neg_w(b_s, b_signed_s & b_s[W-1]);
        neg_q_s  = (a_signed_s & a_s[W-1]) ^ (b_signed_s & b_s[W-1]);
        neg_r_s  = a_signed_s & a_s[W-1];
        b_zero_s = (b_s == {W{1'b0}});
        ovf_s    = a_signed_s & b_signed_s & fn_s[2] &
                   (a_s == MOST_NEG) & (b_s == ALL_ONES);

        case (fn_s)
            FN_DIV: begin
                if (b_zero_s) begin
                    special_s = 1'b1; special_res_s = ALL_ONES;
                end else if (ovf_s) begin
                    special_s = 1'b1; special_res_s = a_s;
                end else begin
                    special_s = 1'b0; special_res_s = {W{1'b0}};
                end
            end
            FN_DIVU: begin
                if (b_zero_s) begin
                    special_s = 1'b1; special_res_s = ALL_ONES;
                end else begin
                    special_s = 1'b0; special_res_s = {W{1'b0}};
                end
            end
            FN_REM: begin
                if (b_zero_s) begin
                    special_s = 1'b1; special_res_s = a_s;
                end else if (ovf_s) begin
                    special_s = 1'b1; special_res_s = {W{1'b0}};
                end else begin
                    special_s = 1'b0; special_res_s = {W{1'b0}};
                end
            end
            FN_REMU: begin
                if (b_zero_s) begin
                    special_s = 1'b1; special_res_s = a_s;
                end else begin
                    special_s = 1'b0; special_res_s = {W{1'b0}};
                end
            end
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
            FN_MUL: begin
                // Zero multiplier: product is zero, skip CALC entirely.
                if (b_zero_s) begin
                    special_s = 1'b1; special_res_s = {W{1'b0}};
                end else begin
                    special_s = 1'b0; special_res_s = {W{1'b0}};
                end
            end
`endif
            default: begin
                special_s     = 1'b0;
                special_res_s = {W{1'b0}};
            end
        endcase
    end

    // One shift-add and one restoring-divide step, plus the final fixup.
    always_comb begin
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
        mcand_step_s  = {mcand_r[2*W-2:0], 1'b0};
        mplier_step_s = {1'b0, mplier_r[W-1:1]};

        // Partial remainder is W+1 bits wide; bit W of the difference is
        // the borrow that decides the quotient bit.
        rem_shift_s = {rem_r, quo_r[W-1]};
        diff_s      = rem_shift_s - {1'b0, divisor_r};
        if (!diff_s[W]) begin
            rem_step_s = diff_s[W-1:0];
            quo_step_s = {quo_r[W-2:0], 1'b1};
        end else begin
            rem_step_s = rem_shift_s[W-1:0];
            quo_step_s = {quo_r[W-2:0], 1'b0};
        end

        prod_s = cond_neg_2w(acc_step_s, sign_fix_r);

        case (fn_r)
            FN_MUL:                      final_res_s = prod_s[W-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: final_res_s = prod_s[2*W-1:W];
            FN_DIV, FN_DIVU:             final_res_s = cond_neg_w(quo_step_s, sign_fix_r);
            FN_REM, FN_REMU:             final_res_s = cond_neg_w(rem_step_s, sign_fix_r);
            default:                     final_res_s = {W{1'b0}};
        endcase
    end

    // Decide whether the current CALC cycle is the final iteration.
    always_comb begin
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
        last_iter_s = (cnt_r == CNT_ONE) ||
                      ((fn_r == FN_MUL) && (mplier_step_s == {W{1'b0}}));
`else
        last_iter_s = (cnt_r == CNT_ONE);
`endif
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (special_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (ostream_rdy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            istream_rdy_r <= 1'b1;
            ostream_val_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            istream_rdy_r <= (state_next_s == ST_IDLE);
            ostream_val_r <= (state_next_s == ST_DONE);
            busy_r        <= (state_next_s != ST_IDLE);
        end
    end

    // Datapath: load on accept, iterate in CALC, hold in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r      <= {p_cnt_bits{1'b0}};
            fn_r       <= 3'd0;
            sign_fix_r <= 1'b0;
            acc_r      <= {(2*W){1'b0}};
            mcand_r    <= {(2*W){1'b0}};
            mplier_r   <= {W{1'b0}};
            rem_r      <= {W{1'b0}};
            quo_r      <= {W{1'b0}};
            divisor_r  <= {W{1'b0}};
            result_r   <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        fn_r       <= fn_s;
                        // REM/REMU follow the dividend sign, all others the
                        // XOR of operand signs.
                        sign_fix_r <= (fn_s[2] & fn_s[1]) ? neg_r_s : neg_q_s;
                        acc_r      <= {(2*W){1'b0}};
                        mcand_r    <= {{W{1'b0}}, a_mag_s};
                        mplier_r   <= b_mag_s;
                        rem_r      <= {W{1'b0}};
                        quo_r      <= a_mag_s;
                        divisor_r  <= b_mag_s;
                        cnt_r      <= CNT_INIT;
                        if (special_s) begin
                            result_r <= special_res_s;
                        end
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_step_s;
                    mcand_r  <= mcand_step_s;
                    mplier_r <= mplier_step_s;
                    rem_r    <= rem_step_s;
                    quo_r    <= quo_step_s;
                    cnt_r    <= cnt_r - CNT_ONE;
                    if (last_iter_s) begin
                        result_r <= final_res_s;
                    end
                end
                ST_DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign istream_rdy = istream_rdy_r;
    assign ostream_val = ostream_val_r;
    assign ostream_msg = result_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_lab2_proc_int_muldiv_iter.sv
// ============================================================================
// tb_lab2_proc_int_muldiv_iter
// ----------------------------------------------------------------------------
// Directed, table-driven bench for lab2_proc_int_muldiv_iter at W=32.
// Each table record carries the request and the hand-computed result and
// latency (cycles from accept edge to first ostream_val). Hand-written
// sequences cover reset state, output backpressure and reset mid-CALC.
// ============================================================================
module tb_lab2_proc_int_muldiv_iter;

    localparam int W    = 32;
    localparam int FULL = W + 1;
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    typedef struct {
        logic [2:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
        string        name;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             istream_val;
    logic             istream_rdy;
    logic [2*W+2:0]   istream_msg;
    logic             ostream_val;
    logic             ostream_rdy;
    logic [W-1:0]     ostream_msg;
    logic             busy;

    int n_cmp;
    int n_err;
    vec_t vq[$];

    lab2_proc_int_muldiv_iter #(.p_width(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fn, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res,
                                input int lat, input string name);
        vec_t v;
        v.fn = fn; v.a = a; v.b = b; v.res = res; v.lat = lat; v.name = name;
        return v;
    endfunction

    // Issue one request with ostream_rdy=1 and check result and latency.
    task automatic run_op(input vec_t v);
        int lat;
        int guard;
        guard = 0;
        while (!istream_rdy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({v.name, " istream_rdy"}, 64'(istream_rdy), 64'd1);
        istream_val = 1'b1;
        istream_msg = {v.fn, v.a, v.b};
        @(posedge clk); #1;
        istream_val = 1'b0;
        lat = 1;
        while (!ostream_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " result"}, 64'(ostream_msg), 64'(v.res));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic saw;
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b1;

        vq.push_back(mk(MUL,    32'h3,        32'hFFFFFFFE, 32'hFFFFFFFA, FULL, "mul_3_m2"));
        vq.push_back(mk(MULHU,  32'h3,        32'hFFFFFFFE, 32'h00000002, FULL, "mulhu_3"));
        vq.push_back(mk(MULH,   32'h80000000, 32'h80000000, 32'h40000000, FULL, "mulh_min2"));
        vq.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, FULL, "mulhsu_m1_2"));
        vq.push_back(mk(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL, "mulh_m1_m1"));
        vq.push_back(mk(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL, "mulhu_max"));
        vq.push_back(mk(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, FULL, "mul_max"));
        vq.push_back(mk(MUL,    32'h7,        32'h6,        32'h0000002A, EO ? 4 : FULL, "mul_7_6"));
        vq.push_back(mk(DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, FULL, "div_m7_2"));
        vq.push_back(mk(REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, FULL, "rem_m7_2"));
        vq.push_back(mk(DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, FULL, "div_7_m2"));
        vq.push_back(mk(REM,    32'h7,        32'hFFFFFFFE, 32'h00000001, FULL, "rem_7_m2"));
        vq.push_back(mk(DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, FULL, "div_m7_m2"));
        vq.push_back(mk(REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, FULL, "rem_m7_m2"));
        vq.push_back(mk(DIVU,   32'd100,      32'd7,        32'd14,       FULL, "divu_100_7"));
        vq.push_back(mk(REMU,   32'd100,      32'd7,        32'd2,        FULL, "remu_100_7"));
        vq.push_back(mk(DIVU,   32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, FULL, "divu_max_1"));
        vq.push_back(mk(REMU,   32'h3,        32'h7,        32'h00000003, FULL, "remu_3_7"));
        vq.push_back(mk(DIV,    32'h80000000, 32'h1,        32'h80000000, FULL, "div_min_1"));
        vq.push_back(mk(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,    "divu_by0"));
        vq.push_back(mk(REM,    32'd5,        32'd0,        32'd5,        1,    "rem_by0"));
        vq.push_back(mk(REMU,   32'd0,        32'd0,        32'd0,        1,    "remu_0_by0"));
        vq.push_back(mk(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,    "div_ovf"));
        vq.push_back(mk(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,    "rem_ovf"));
        vq.push_back(mk(MUL,    32'd5,        32'd1,        32'd5,        EO ? 2 : FULL, "mul_5_1"));
        vq.push_back(mk(MUL,    32'd5,        32'd0,        32'd0,        EO ? 1 : FULL, "mul_5_0"));
        vq.push_back(mk(MUL,    32'd1,        32'h80000000, 32'h80000000, FULL, "mul_1_msb"));

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset istream_rdy", 64'(istream_rdy), 64'd1);
        chk("reset ostream_val", 64'(ostream_val), 64'd0);
        chk("reset ostream_msg", 64'(ostream_msg), 64'd0);
        chk("reset busy",        64'(busy),        64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        foreach (vq[i]) begin
            run_op(vq[i]);
        end

        // Backpressure: hold ostream_rdy low for 10 cycles in DONE
        ostream_rdy = 1'b0;
        istream_val = 1'b1;
        istream_msg = {DIVU, 32'd100, 32'd7};
        @(posedge clk); #1;
        istream_val = 1'b0;
        lat = 1;
        while (!ostream_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", 64'(lat), 64'(FULL));
        for (int k = 0; k < 10; k++) begin
            chk("bp ostream_val", 64'(ostream_val), 64'd1);
            chk("bp ostream_msg", 64'(ostream_msg), 64'd14);
            chk("bp istream_rdy", 64'(istream_rdy), 64'd0);
            chk("bp busy",        64'(busy),        64'd1);
            @(posedge clk); #1;
        end
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp release istream_rdy", 64'(istream_rdy), 64'd1);
        chk("bp release ostream_val", 64'(ostream_val), 64'd0);
        chk("bp release busy",        64'(busy),        64'd0);

        // Reset in CALC cycle 5 discards the request
        istream_val = 1'b1;
        istream_msg = {MUL, 32'h3, 32'hFFFFFFFE};
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("calc busy",        64'(busy),        64'd1);
        chk("calc istream_rdy", 64'(istream_rdy), 64'd0);
        reset = 1'b0;
        #1;
        chk("midreset istream_rdy", 64'(istream_rdy), 64'd1);
        chk("midreset busy",        64'(busy),        64'd0);
        chk("midreset ostream_val", 64'(ostream_val), 64'd0);
        #1 reset = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ostream_val) saw = 1'b1;
        end
        chk("midreset no response", 64'(saw), 64'd0);

        // Unit still works after the mid-operation reset
        run_op(mk(REMU, 32'd100, 32'd7, 32'd2, FULL, "post_reset_remu"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
